// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forward-select encodings,
// default MDU latencies and the Tuse/Tnew values emitted by the controller decoder.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // Tuse: cycles from D until the operand is consumed.
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;

  // Tnew: cycles from the current stage until the result exists.
  localparam logic [1:0] TNEW_READY = 2'd0;
  localparam logic [1:0] TNEW_ALU   = 2'd1;
  localparam logic [1:0] TNEW_LOAD  = 2'd2;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks how long the multiply/divide unit stays busy after a launch from E.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic [CntW-1:0] md_cnt_d, md_cnt_q;

  // A launch always reloads, so an illegal overlapping launch means latest wins.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = md_is_div ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);

  overlap_launch: assert property (@(posedge clk) disable iff (reset) !(md_start && md_busy))
    else $error("md_busy_tracker: MDU launched while still busy");

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline with an MDU busy tracker.
// Defining HAZARD_STALL_CNT_EN adds the saturating stall_cnt output.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned T_W      = 2,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
`ifdef HAZARD_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rs_read_D,
  input  logic              rt_read_D,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [T_W-1:0]    rs_tuse_D,
  input  logic [T_W-1:0]    rt_tuse_D,
  input  logic [REG_AW-1:0] a3_E,
  input  logic [REG_AW-1:0] a3_M,
  input  logic [REG_AW-1:0] a3_W,
  input  logic [T_W-1:0]    tnew_E,
  input  logic [T_W-1:0]    tnew_M,
  input  logic              md_use_D,
  input  logic              md_start_E,
  input  logic              md_is_div_E,
  output logic              stall_pc,
  output logic              stall_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
`ifdef HAZARD_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              md_busy
);

  logic rs_clash, rt_clash, md_clash, stall;

  function automatic logic data_clash(input logic              rd,
                                      input logic [REG_AW-1:0] src,
                                      input logic [T_W-1:0]    tuse,
                                      input logic [REG_AW-1:0] a3,
                                      input logic [T_W-1:0]    tnew);
    return rd && (src == a3) && (a3 != '0) && (tuse < tnew);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] e,
                                         input logic [T_W-1:0]    te,
                                         input logic [REG_AW-1:0] m,
                                         input logic [T_W-1:0]    tm,
                                         input logic [REG_AW-1:0] w);
    if (src == e && e != '0 && te == '0) return FWD_E;
    if (src == m && m != '0 && tm == '0) return FWD_M;
    if (src == w && w != '0) return FWD_W;
    return FWD_RF;
  endfunction

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start_E),
    .md_is_div (md_is_div_E),
    .md_busy   (md_busy)
  );

  always_comb begin
    rs_clash = data_clash(rs_read_D, rs_D, rs_tuse_D, a3_E, tnew_E) |
               data_clash(rs_read_D, rs_D, rs_tuse_D, a3_M, tnew_M);
    rt_clash = data_clash(rt_read_D, rt_D, rt_tuse_D, a3_E, tnew_E) |
               data_clash(rt_read_D, rt_D, rt_tuse_D, a3_M, tnew_M);
    // The launch cycle itself also stalls, before md_busy has risen.
    md_clash = md_use_D && (md_busy || md_start_E);
    stall    = rs_clash || rt_clash || md_clash;
  end

  assign stall_pc = stall;
  assign stall_id = stall;
  assign flush_ex = stall;

  assign fwd_rs_D = fwd_sel(rs_D, a3_E, tnew_E, a3_M, tnew_M, a3_W);
  assign fwd_rt_D = fwd_sel(rt_D, a3_E, tnew_E, a3_M, tnew_M, a3_W);

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
